dpsram_port_arbiter: RTL and testbench
======================================

// Module: dpsram_port_arbiter
//
// PURPOSE
//   Round-robin arbiter that shares one read/write port of the dual-ported
//   SRAM (dpsram) between NUM_REQ requesters, e.g. the DMA, debug and host
//   masters. At most one access is issued per cycle. The read result is
//   returned one cycle later, tagged with the requester ID. A lock option
//   keeps the grant for back-to-back read-modify-write sequences.
//
// PARAMETERS
//   NUM_REQ     4     number of requesters (2..8)
//   DATA_WIDTH  16    SRAM word width; must match dpsram
//   ADDR_WIDTH  12    SRAM address width; must match dpsram
//   ID_WIDTH    $clog2(NUM_REQ)  width of requester ID
//
// PORTS
//   clk         in   1                       clock
//   reset_n     in   1                       async active-low reset
//   req_valid   in   NUM_REQ                 per-requester access request
//   req_we      in   NUM_REQ                 1=write, 0=read
//   req_lock    in   NUM_REQ                 keep grant after this access
//   req_addr    in   NUM_REQ*ADDR_WIDTH      packed, requester i at [i*AW +: AW]
//   req_wdata   in   NUM_REQ*DATA_WIDTH      packed write data
//   req_ack     out  NUM_REQ                 one-hot: access issued this cycle
//   rsp_valid   out  1                       read data valid (reads only)
//   rsp_id      out  ID_WIDTH                requester that owns rsp_data
//   rsp_data    out  DATA_WIDTH              read data
//   sram_addr   out  ADDR_WIDTH              to dpsram addr_x
//   sram_we     out  1                       to dpsram we_x
//   sram_wdata  out  DATA_WIDTH              to dpsram data_x
//   sram_q      in   DATA_WIDTH              from dpsram q_x
//
// BEHAVIOUR
//   - Reset (async): prio_ptr=0, lock_owner_valid=0, rsp_valid=0, rsp_id=0.
//     rsp_data is a pass-through of sram_q and is not reset.
//   - Grant is combinational in the same cycle. If a lock is held, the owner
//     wins whenever it has req_valid. Otherwise the first valid requester at
//     or after prio_ptr wins, searching upward with wrap from NUM_REQ-1 to 0.
//   - req_ack[g]=1 only for the winner. sram_addr, sram_we and sram_wdata are
//     muxed from the winner.
//   - With no winner: sram_we=0, sram_addr=0, sram_wdata=0, req_ack=0.
//   - Requesters hold valid, we, addr and wdata stable until acked. The ack
//     cycle is the transfer, so a new request may follow on the next cycle.
//   - On each grant with no lock held, prio_ptr <= (g+1) mod NUM_REQ.
//     prio_ptr does not change while a lock is held.
//   - Lock: if granted with req_lock[g]=1, then owner <= g and
//     lock_owner_valid <= 1. The lock is released on a granted owner access
//     with req_lock=0, at which point prio_ptr <= owner+1.
//   - While locked and the owner has req_valid=0, the port idles and no other
//     requester is granted. Owners must not leave a lock held while idle
//     indefinitely.
//   - Read latency is 1 cycle. A read granted in cycle N gives rsp_valid=1 in
//     N+1 with rsp_id=N's winner and rsp_data=sram_q.
//   - Writes produce no response: rsp_valid=0 in the following cycle.
//   - Back-to-back reads give one rsp_valid per cycle, in grant order.
//   - Simultaneous requests from all NUM_REQ: each is served exactly once in
//     NUM_REQ consecutive cycles.
//   - Reset mid-operation: any pending response and lock are discarded.
//     Requesters must reissue.
//
// STRUCTURE
//   - Shared package (pasc_mem_pkg): SRAM_DATA_WIDTH, SRAM_ADDR_WIDTH and the
//     requester ID enum (REQ_HOST=0, REQ_DMA=1, REQ_DEBUG=2, REQ_SPARE=3).
//   - Sub-module rr_priority_pick: inputs req mask and pointer; outputs
//     one-hot grant plus encoded index. It is purely combinational and reused
//     by other arbiters.
//   - Top level holds prio_ptr, the lock owner register, the response
//     pipeline register and the datapath muxes.
//
// TESTING
//   1. Reset: hold reset_n=0 with all req_valid=1 -> req_ack=0, rsp_valid=0,
//      sram_we=0. On release, first grant goes to requester 0.
//   2. Single read: req 2 reads addr 0x123 holding 0xBEEF -> req_ack=4'b0100
//      the same cycle; next cycle rsp_valid=1, rsp_id=2, rsp_data=0xBEEF.
//   3. Fairness: all 4 request reads continuously for 8 cycles -> ack order
//      0,1,2,3,0,1,2,3 and 8 responses with matching IDs.
//   4. Write then read: req 1 writes 0x0A5A to 0x010, then reads 0x010 ->
//      no rsp after the write; rsp_data=0x0A5A, rsp_id=1 after the read.
//   5. Lock RMW: req 3 reads 0x020 with lock=1 while req 0 and 1 request.
//      Req 3 then writes 0x020 with lock=0 -> 3 is granted in consecutive
//      cycles, then 0 and 1 are served.
//   6. Async reset mid-read: assert reset_n=0 in the cycle after a read
//      grant -> rsp_valid drops to 0 immediately and the lock clears.

Source files
------------

// File: rtl/pasc_mem_pkg.sv
// Shared definitions for the dpsram memory subsystem.
// Holds the SRAM geometry and the fixed requester ID assignment.
package pasc_mem_pkg;

  localparam int SRAM_DATA_WIDTH = 16;
  localparam int SRAM_ADDR_WIDTH = 12;

  typedef enum logic [1:0] {
    REQ_HOST  = 2'd0,
    REQ_DMA   = 2'd1,
    REQ_DEBUG = 2'd2,
    REQ_SPARE = 2'd3
  } req_id_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set bit of req at or after ptr,
// wrapping from N-1 back to 0. Returns one-hot grant plus encoded index.
module rr_priority_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(ptr) + i) % N);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/dpsram_port_arbiter.sv
// Round-robin arbiter sharing one dpsram port between NUM_REQ requesters,
// with a lock for read-modify-write and a one-cycle tagged read response.
module dpsram_port_arbiter
  import pasc_mem_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ-1:0]            req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic                          rsp_valid,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [ADDR_WIDTH-1:0]         sram_addr,
  output logic                          sram_we,
  output logic [DATA_WIDTH-1:0]         sram_wdata,
  input  logic [DATA_WIDTH-1:0]         sram_q
);

  logic [ID_WIDTH-1:0] prio_ptr;
  logic [ID_WIDTH-1:0] lock_owner;
  logic                lock_owner_valid;

  logic [NUM_REQ-1:0]  pick_grant;
  logic [ID_WIDTH-1:0] pick_idx;
  logic                pick_any;
  logic [ID_WIDTH-1:0] win_idx;
  logic                win_valid;
  int                  win_sel;

  function automatic logic [ID_WIDTH-1:0] next_ptr(input logic [ID_WIDTH-1:0] idx);
    return (idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  rr_priority_pick #(
    .N  (NUM_REQ),
    .IW (ID_WIDTH)
  ) u_pick (
    .req   (req_valid),
    .ptr   (prio_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // A held lock overrides round-robin; the port stays idle if the owner is quiet.
  always_comb begin
    win_idx    = pick_idx;
    win_valid  = 1'b0;
    win_sel    = 0;
    req_ack    = '0;
    sram_addr  = '0;
    sram_we    = 1'b0;
    sram_wdata = '0;
    if (reset_n) begin
      if (lock_owner_valid) begin
        win_idx   = lock_owner;
        win_valid = req_valid[lock_owner];
      end else begin
        win_valid = pick_any && (pick_grant != '0);
      end
    end
    if (win_valid) begin
      win_sel          = int'(win_idx);
      req_ack[win_idx] = 1'b1;
      sram_addr        = req_addr[win_sel*ADDR_WIDTH +: ADDR_WIDTH];
      sram_we          = req_we[win_idx];
      sram_wdata       = req_wdata[win_sel*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_ptr         <= '0;
      lock_owner       <= '0;
      lock_owner_valid <= 1'b0;
      rsp_valid        <= 1'b0;
      rsp_id           <= '0;
    end else begin
      rsp_valid <= win_valid && !sram_we;
      if (win_valid && !sram_we) begin
        rsp_id <= win_idx;
      end
      if (win_valid) begin
        if (lock_owner_valid) begin
          if (!req_lock[win_idx]) begin
            lock_owner_valid <= 1'b0;
            prio_ptr         <= next_ptr(lock_owner);
          end
        end else begin
          prio_ptr <= next_ptr(win_idx);
          if (req_lock[win_idx]) begin
            lock_owner       <= win_idx;
            lock_owner_valid <= 1'b1;
          end
        end
      end
    end
  end

  assign rsp_data = sram_q;

endmodule

// File: tb/tb_dpsram_port_arbiter.sv
// Directed bench for dpsram_port_arbiter with a behavioural SRAM and a
// scoreboard of expected read responses.
module tb_dpsram_port_arbiter;
  import pasc_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req_valid, req_we, req_lock, req_ack;
  logic [47:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid, sram_we;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data, sram_wdata, sram_q;
  logic [11:0] sram_addr;

  logic [15:0] mem     [0:4095];
  logic        written [0:4095];
  logic        mem_clear;

  typedef struct {
    int          cyc;
    logic [1:0]  id;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] shadow[int];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  dpsram_port_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_lock   (req_lock),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ack    (req_ack),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .sram_addr  (sram_addr),
    .sram_we    (sram_we),
    .sram_wdata (sram_wdata),
    .sram_q     (sram_q)
  );

  function automatic logic [15:0] default_word(input logic [11:0] a);
    return (a == 12'h123) ? 16'hBEEF : {4'hC, a};
  endfunction

  function automatic logic [15:0] expected_word(input logic [11:0] a);
    return shadow.exists(int'(a)) ? shadow[int'(a)] : default_word(a);
  endfunction

  // Synchronous single-port SRAM with read-before-write and one-cycle read latency.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 4096; i++) written[i] <= 1'b0;
    end else if (sram_we) begin
      mem[sram_addr]     <= sram_wdata;
      written[sram_addr] <= 1'b1;
    end
    sram_q <= written[sram_addr] ? mem[sram_addr] : default_word(sram_addr);
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic apply_stimulus(input int i, input logic v, input logic w, input logic l,
                                input logic [11:0] a, input logic [15:0] d);
    req_valid[i]         = v;
    req_we[i]            = w;
    req_lock[i]          = l;
    req_addr[i*12 +: 12] = a;
    req_wdata[i*16 +: 16] = d;
  endtask

  // One arbitration cycle: check the response owed from the previous cycle,
  // check the grant and SRAM port, then record what the grant will return.
  task automatic run_cycle(input logic [3:0] exp_ack, input string tag);
    exp_t        e;
    int          g;
    logic [11:0] a;
    @(negedge clk);
    if (sb.size() > 0 && sb[0].cyc == cyc - 1) begin
      e = sb.pop_front();
      check_output({tag, "_rsp_valid"}, rsp_valid, 1);
      check_output({tag, "_rsp_id"}, rsp_id, e.id);
      check_output({tag, "_rsp_data"}, rsp_data, e.data);
    end else begin
      check_output({tag, "_no_rsp"}, rsp_valid, 0);
    end
    check_output({tag, "_ack"}, req_ack, exp_ack);
    if (exp_ack != 4'b0000) begin
      g = 0;
      for (int i = 0; i < 4; i++) if (exp_ack[i]) g = i;
      a = req_addr[g*12 +: 12];
      check_output({tag, "_addr"}, sram_addr, a);
      check_output({tag, "_we"}, sram_we, req_we[g]);
      if (req_we[g]) begin
        check_output({tag, "_wdata"}, sram_wdata, req_wdata[g*16 +: 16]);
        shadow[int'(a)] = req_wdata[g*16 +: 16];
      end else begin
        e.cyc  = cyc;
        e.id   = 2'(g);
        e.data = expected_word(a);
        sb.push_back(e);
      end
    end else begin
      check_output({tag, "_idle_we"}, sram_we, 0);
      check_output({tag, "_idle_addr"}, sram_addr, 0);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    mem_clear = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_lock  = '0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < 4; i++) apply_stimulus(i, 1'b1, 1'b1, 1'b0, 12'(i*256 + 64), 16'h1111);

    // Reset held with every requester asking: nothing may be issued.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset_ack", req_ack, 0);
    check_output("reset_rsp_valid", rsp_valid, 0);
    check_output("reset_sram_we", sram_we, 0);
    @(posedge clk);
    #1;
    req_we    = '0;
    mem_clear = 1'b0;
    reset_n   = 1'b1;

    // Fairness: all four read continuously, first grant goes to requester 0.
    for (int k = 0; k < 8; k++) run_cycle(4'b0001 << (k % 4), "fair");
    req_valid = '0;
    run_cycle(4'b0000, "fair_drain");

    // Single read from the debug master.
    apply_stimulus(REQ_DEBUG, 1'b1, 1'b0, 1'b0, 12'h123, 16'h0000);
    run_cycle(4'b0100, "single_read");
    req_valid = '0;
    run_cycle(4'b0000, "single_rsp");

    // Write then read back through the same requester.
    apply_stimulus(REQ_DMA, 1'b1, 1'b1, 1'b0, 12'h010, 16'h0A5A);
    run_cycle(4'b0010, "wr");
    apply_stimulus(REQ_DMA, 1'b1, 1'b0, 1'b0, 12'h010, 16'h0000);
    run_cycle(4'b0010, "rd_after_wr");
    req_valid = '0;
    run_cycle(4'b0000, "rd_after_wr_rsp");

    // Locked read-modify-write by requester 3 while 0 and 1 wait.
    apply_stimulus(0, 1'b1, 1'b0, 1'b0, 12'h030, 16'h0000);
    apply_stimulus(1, 1'b1, 1'b0, 1'b0, 12'h031, 16'h0000);
    apply_stimulus(3, 1'b1, 1'b0, 1'b1, 12'h020, 16'h0000);
    run_cycle(4'b1000, "lock_rd");
    apply_stimulus(3, 1'b0, 1'b0, 1'b1, 12'h020, 16'h0000);
    run_cycle(4'b0000, "lock_idle");
    apply_stimulus(3, 1'b1, 1'b1, 1'b0, 12'h020, 16'h1234);
    run_cycle(4'b1000, "lock_wr");
    req_valid[3] = 1'b0;
    run_cycle(4'b0001, "after_unlock0");
    req_valid[0] = 1'b0;
    run_cycle(4'b0010, "after_unlock1");
    req_valid = '0;
    run_cycle(4'b0000, "after_unlock_rsp");

    // Reset asserted while a locked read response is outstanding.
    apply_stimulus(3, 1'b1, 1'b0, 1'b1, 12'h040, 16'h0000);
    run_cycle(4'b1000, "rst_lock_rd");
    req_valid = '0;
    #2;
    check_output("rst_rsp_before", rsp_valid, 1);
    check_output("rst_rsp_id_before", rsp_id, 3);
    reset_n = 1'b0;
    #1;
    check_output("rst_rsp_dropped", rsp_valid, 0);
    check_output("rst_rsp_id_cleared", rsp_id, 0);
    sb.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    apply_stimulus(0, 1'b1, 1'b0, 1'b0, 12'h050, 16'h0000);
    apply_stimulus(3, 1'b1, 1'b0, 1'b0, 12'h060, 16'h0000);
    run_cycle(4'b0001, "rst_lock_gone");
    req_valid[0] = 1'b0;
    run_cycle(4'b1000, "rst_next");
    req_valid = '0;
    run_cycle(4'b0000, "rst_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
